// File: rtl/mnist_verify_pkg.sv
// Shared types, widths and the signed-argmax helper for the MNIST batch
// verification controller.
package mnist_verify_pkg;

  typedef logic [3:0] state_t;

  localparam state_t ST_IDLE     = 4'd0;
  localparam state_t ST_START    = 4'd1;
  localparam state_t ST_STREAM   = 4'd2;
  localparam state_t ST_WAIT_RES = 4'd3;
  localparam state_t ST_COMPARE  = 4'd4;
  localparam state_t ST_HOLD     = 4'd5;
  localparam state_t ST_NEXT     = 4'd6;
  localparam state_t ST_DONE     = 4'd7;
  localparam state_t ST_ERR      = 4'd8;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_NUM_CLASS = 10;
  localparam int DEF_NUM_IMG   = 4;
  localparam int CLS_W         = clog2_min1(DEF_NUM_CLASS);
  localparam int IDX_W         = clog2_min1(DEF_NUM_IMG);

  // Upper bounds of the argmax helper; callers zero-extend their vector.
  localparam int MAX_CLASS   = 64;
  localparam int MAX_SCORE_W = 32;
  localparam int MAX_VEC     = MAX_CLASS * MAX_SCORE_W;

  // Signed argmax over num_class scores of score_w bits; ties go to the
  // lowest index because only a strictly greater score replaces the best.
  function automatic logic [31:0] signed_argmax(input logic [MAX_VEC-1:0] vec,
                                                input int num_class,
                                                input int score_w);
    logic [63:0]        mask;
    logic [63:0]        raw;
    logic signed [63:0] cur;
    logic signed [63:0] best;
    logic [31:0]        idx;
    mask = (64'd1 << score_w) - 64'd1;
    best = '0;
    idx  = '0;
    for (int k = 0; k < MAX_CLASS; k++) begin
      if (k < num_class) begin
        raw = 64'(vec >> (k * score_w)) & mask;
        if (((raw >> (score_w - 1)) & 64'd1) != 64'd0) begin
          cur = signed'(raw | ~mask);
        end else begin
          cur = signed'(raw);
        end
        if (k == 0 || cur > best) begin
          best = cur;
          idx  = 32'(k);
        end
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/mnist_verify_ctrl_key_debounce.sv
// Two-flop synchroniser plus stability-count debouncer for the push button;
// emits a one-cycle pulse on each accepted rising edge.
module key_debounce
  import mnist_verify_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise_pulse
);

  localparam int CNT_W = clog2_min1(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta;
  logic             sync;
  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments only, and reset is
  // sampled on the clock edge rather than in the sensitivity list.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta       <= 1'b0;
      sync       <= 1'b0;
      level      <= 1'b0;
      rise_pulse <= 1'b0;
      cnt        <= '0;
    end else begin
      meta       <= din;
      sync       <= meta;
      rise_pulse <= 1'b0;
      if (sync == level) begin
        cnt <= '0;
      end else if (cnt >= CNT_LAST) begin
        cnt        <= '0;
        level      <= sync;
        rise_pulse <= sync;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/mnist_verify_ctrl.sv
// Batch verification controller: streams NUM_IMG images through the core,
// checks each argmax against the expected label and reports on LEDs.
module mnist_verify_ctrl
  import mnist_verify_pkg::*;
#(
  parameter int NUM_CLASS       = 10,
  parameter int SCORE_W         = 8,
  parameter int PIX_PER_IMG     = 784,
  parameter int NUM_IMG         = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HOLD_CYCLES     = 50000000,
  parameter int TIMEOUT_CYCLES  = 2000000
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    key_in,
  output logic                                    img_start,
  output logic [clog2_min1(NUM_IMG)-1:0]          img_idx,
  input  logic                                    pix_vld,
  input  logic [clog2_min1(NUM_CLASS)-1:0]        exp_label,
  input  logic [NUM_CLASS*SCORE_W-1:0]            res_din,
  input  logic                                    res_vld,
  input  logic                                    res_end,
  output logic [clog2_min1(NUM_CLASS)-1:0]        pred_label,
  output logic                                    led_pass,
  output logic                                    led_busy,
  output logic [clog2_min1(NUM_IMG+1)-1:0]        pass_cnt,
  output logic [clog2_min1(NUM_IMG+1)-1:0]        fail_cnt,
  output logic                                    done,
  output logic                                    err_timeout,
  output logic                                    err_proto
);

  localparam int LBL_W    = clog2_min1(NUM_CLASS);
  localparam int IDX_BITS = clog2_min1(NUM_IMG);
  localparam int CNT_W    = clog2_min1(NUM_IMG + 1);
  localparam int PX_W     = clog2_min1(PIX_PER_IMG + 1);
  localparam int HOLD_W   = clog2_min1(HOLD_CYCLES + 1);
  localparam int TO_W     = clog2_min1(TIMEOUT_CYCLES + 1);

  localparam logic [PX_W-1:0]     PIX_LAST  = PX_W'(PIX_PER_IMG - 1);
  localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [TO_W-1:0]     TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_BITS-1:0] IDX_LAST  = IDX_BITS'(NUM_IMG - 1);

  logic                         unused_key_level;
  logic                         key_go;
  state_t                       state;
  logic [PX_W-1:0]              pix_cnt;
  logic [HOLD_W-1:0]            hold_cnt;
  logic [TO_W-1:0]              to_cnt;
  logic [NUM_CLASS*SCORE_W-1:0] res_cap;
  logic [LBL_W-1:0]             pred_now;
  logic                         timed_out;
  logic                         proto_hit;
  logic                         key_ok;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key (
    .clk       (clk),
    .rst       (rst),
    .din       (key_in),
    .level     (unused_key_level),
    .rise_pulse(key_go)
  );

  assign img_start = (state == ST_START);
  assign pred_now  = LBL_W'(signed_argmax(MAX_VEC'(res_cap), NUM_CLASS, SCORE_W));
  assign timed_out = (to_cnt >= TO_LAST);
  assign key_ok    = key_go && (state == ST_IDLE || state == ST_DONE || state == ST_ERR);
  assign proto_hit = (pix_vld && state != ST_STREAM) ||
                     (res_vld && res_end && state != ST_WAIT_RES);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      img_idx     <= '0;
      pix_cnt     <= '0;
      hold_cnt    <= '0;
      to_cnt      <= '0;
      res_cap     <= '0;
      pred_label  <= '0;
      led_pass    <= 1'b0;
      led_busy    <= 1'b0;
      pass_cnt    <= '0;
      fail_cnt    <= '0;
      done        <= 1'b0;
      err_timeout <= 1'b0;
      err_proto   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (key_ok) begin
            state       <= ST_START;
            img_idx     <= '0;
            pass_cnt    <= '0;
            fail_cnt    <= '0;
            done        <= 1'b0;
            err_timeout <= 1'b0;
            err_proto   <= 1'b0;
            led_busy    <= 1'b1;
            led_pass    <= 1'b0;
          end
        end
        ST_START: begin
          // The START cycle is the first cycle of the timeout window.
          pix_cnt <= '0;
          to_cnt  <= TO_W'(1);
          state   <= ST_STREAM;
        end
        ST_STREAM: begin
          if (timed_out) begin
            err_timeout <= 1'b1;
            led_busy    <= 1'b0;
            led_pass    <= 1'b0;
            state       <= ST_ERR;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
            if (pix_vld) begin
              pix_cnt <= pix_cnt + PX_W'(1);
              if (pix_cnt == PIX_LAST) begin
                state <= ST_WAIT_RES;
              end
            end
          end
        end
        ST_WAIT_RES: begin
          if (res_vld && res_end) begin
            res_cap <= res_din;
            state   <= ST_COMPARE;
          end else if (timed_out) begin
            err_timeout <= 1'b1;
            led_busy    <= 1'b0;
            led_pass    <= 1'b0;
            state       <= ST_ERR;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        ST_COMPARE: begin
          pred_label <= pred_now;
          hold_cnt   <= '0;
          state      <= ST_HOLD;
          if (pred_now == exp_label) begin
            led_pass <= 1'b1;
            if (pass_cnt != '1) pass_cnt <= pass_cnt + CNT_W'(1);
          end else begin
            led_pass <= 1'b0;
            if (fail_cnt != '1) fail_cnt <= fail_cnt + CNT_W'(1);
          end
        end
        ST_HOLD: begin
          if (hold_cnt >= HOLD_LAST) begin
            led_pass <= 1'b0;
            state    <= ST_NEXT;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        ST_NEXT: begin
          if (img_idx == IDX_LAST) begin
            done     <= 1'b1;
            led_busy <= 1'b0;
            led_pass <= (fail_cnt == '0);
            state    <= ST_DONE;
          end else begin
            img_idx <= img_idx + IDX_BITS'(1);
            state   <= ST_START;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // Placed last so a protocol hit in the restart cycle still sticks.
      if (proto_hit) err_proto <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mnist_verify_ctrl.sv
// Self-checking bench for mnist_verify_ctrl with small parameters.
module tb_mnist_verify_ctrl;

  localparam int NUM_CLASS = 10;
  localparam int SCORE_W   = 8;
  localparam int PIX       = 4;
  localparam int NIMG      = 2;
  localparam int DEB       = 3;
  localparam int HOLD      = 5;
  localparam int TO        = 20;
  localparam int NVEC      = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_in;
  logic        img_start;
  logic [0:0]  img_idx;
  logic        pix_vld;
  logic [3:0]  exp_label;
  logic [79:0] res_din;
  logic        res_vld;
  logic        res_end;
  logic [3:0]  pred_label;
  logic        led_pass;
  logic        led_busy;
  logic [1:0]  pass_cnt;
  logic [1:0]  fail_cnt;
  logic        done;
  logic        err_timeout;
  logic        err_proto;

  logic [3:0]  exp_rom [2];
  assign exp_label = exp_rom[img_idx];

  typedef struct {
    logic [79:0] scores;
    logic [3:0]  exp_lbl;
    logic [3:0]  pred;
    logic        pass;
  } img_vec_t;

  img_vec_t vecs [NVEC];
  int n_checks  = 0;
  int n_fail    = 0;
  int start_cnt = 0;

  mnist_verify_ctrl #(
    .NUM_CLASS(NUM_CLASS), .SCORE_W(SCORE_W), .PIX_PER_IMG(PIX), .NUM_IMG(NIMG),
    .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .img_start(img_start), .img_idx(img_idx),
    .pix_vld(pix_vld), .exp_label(exp_label), .res_din(res_din), .res_vld(res_vld),
    .res_end(res_end), .pred_label(pred_label), .led_pass(led_pass), .led_busy(led_busy),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .done(done), .err_timeout(err_timeout),
    .err_proto(err_proto)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (img_start === 1'b1) start_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [79:0] fill_scores(input int fill, input int k1, input int v1,
                                              input int k2, input int v2);
    logic [79:0] s;
    for (int k = 0; k < NUM_CLASS; k++) s[k*8 +: 8] = 8'(fill);
    if (k1 >= 0) s[k1*8 +: 8] = 8'(v1);
    if (k2 >= 0) s[k2*8 +: 8] = 8'(v2);
    return s;
  endfunction

  // Reference: first class holding the largest signed score.
  function automatic logic [3:0] model_argmax(input logic [79:0] s);
    int best;
    int v;
    int idx;
    best = -1000;
    idx  = 0;
    for (int k = 0; k < NUM_CLASS; k++) begin
      v = int'($signed(s[k*8 +: 8]));
      if (v > best) begin
        best = v;
        idx  = k;
      end
    end
    return 4'(idx);
  endfunction

  function automatic logic [14:0] all_outs();
    return {img_start, img_idx, pred_label, led_pass, led_busy, pass_cnt, fail_cnt,
            done, err_timeout, err_proto};
  endfunction

  task automatic press_key();
    key_in = 1'b1;
    repeat (10) @(negedge clk);
    key_in = 1'b0;
  endtask

  task automatic wait_start(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (img_start !== 1'b1 && lat < 40);
    check("img_start_seen", img_start, 1'b1);
  endtask

  task automatic run_image(input int i, input img_vec_t e, output int lat);
    int   hi;
    logic any_hi;
    wait_start(lat);
    check("img_idx", img_idx, i);
    @(negedge clk);
    pix_vld = 1'b1;
    repeat (3) @(negedge clk);
    @(negedge clk);
    pix_vld = 1'b0;
    res_vld = 1'b1;
    res_end = 1'b0;
    res_din = {$urandom, $urandom, 16'($urandom)};
    @(negedge clk);
    res_end = 1'b1;
    res_din = e.scores;
    @(negedge clk);
    res_vld = 1'b0;
    res_end = 1'b0;
    @(negedge clk);
    check("pred_label", pred_label, e.pred);
    check("led_pass_compare", led_pass, e.pass);
    check("led_busy_running", led_busy, 1'b1);
    if (e.pass) begin
      hi = 0;
      while (led_pass === 1'b1 && hi < 20) begin
        hi++;
        @(negedge clk);
      end
      check("hold_high_cycles", hi, HOLD);
    end else begin
      any_hi = 1'b0;
      repeat (HOLD) begin
        any_hi |= led_pass;
        @(negedge clk);
      end
      check("hold_low_cycles", any_hi, 1'b0);
    end
  endtask

  task automatic run_batch(input int b);
    int lat;
    int k;
    int np;
    int nf;
    int starts0;
    img_vec_t e0;
    img_vec_t e1;
    e0 = vecs[2*b];
    e1 = vecs[2*b+1];
    exp_rom[0] = e0.exp_lbl;
    exp_rom[1] = e1.exp_lbl;
    np = int'(e0.pass) + int'(e1.pass);
    nf = 2 - np;
    starts0 = start_cnt;
    if (b == 0) begin
      key_in = 1'b1;
      @(negedge clk);
      key_in = 1'b0;
      @(negedge clk);
      fork
        press_key();
        begin
          repeat (18) @(negedge clk);
          press_key();
        end
      join_none
    end else begin
      fork
        press_key();
      join_none
    end
    run_image(0, e0, lat);
    if (b == 0) check("key_latency_in_range", (lat >= DEB && lat <= 6), 1'b1);
    run_image(1, e1, lat);
    k = 0;
    while (done !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("done", done, 1'b1);
    check("pass_cnt", pass_cnt, np);
    check("fail_cnt", fail_cnt, nf);
    check("led_pass_done", led_pass, (nf == 0));
    check("led_busy_done", led_busy, 1'b0);
    check("err_flags_clean", {err_timeout, err_proto}, 2'b00);
    repeat (10) @(negedge clk);
    check("done_steady", {done, led_pass}, {1'b1, (nf == 0)});
    check("starts_per_batch", start_cnt - starts0, NIMG);
  endtask

  initial begin
    int k;
    int lat;
    int snap;
    logic [79:0] s;
    logic [3:0]  pr;
    logic [3:0]  ex;

    vecs[0] = '{fill_scores(-5, 3, 100, -1, 0), 4'd3, 4'd3, 1'b1};
    vecs[1] = '{fill_scores(-5, 7, 50, -1, 0),  4'd2, 4'd7, 1'b0};
    vecs[2] = '{fill_scores(0, 2, 20, 5, 20),   4'd2, 4'd2, 1'b1};
    vecs[3] = '{fill_scores(-3, 0, -128, 9, 0), 4'd9, 4'd9, 1'b1};
    for (int i = 4; i < NVEC; i++) begin
      for (int c = 0; c < NUM_CLASS; c++) begin
        if (i % 2 == 1) s[c*8 +: 8] = 8'(int'($urandom_range(0, 3)) - 2);
        else            s[c*8 +: 8] = 8'($urandom);
      end
      pr = model_argmax(s);
      ex = ($urandom_range(0, 1) == 1) ? pr : 4'($urandom_range(0, 9));
      vecs[i] = '{s, ex, pr, (ex == pr)};
    end

    rst = 1'b1;
    key_in = 1'b0;
    pix_vld = 1'b0;
    res_vld = 1'b0;
    res_end = 1'b0;
    res_din = '0;
    exp_rom[0] = '0;
    exp_rom[1] = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", all_outs(), '0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_no_start", start_cnt, 0);

    for (int b = 0; b < NVEC / 2; b++) run_batch(b);

    // Timeout: only three pixels, counted from the img_start cycle.
    fork
      press_key();
    join_none
    wait_start(lat);
    k = 0;
    while (err_timeout !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
      pix_vld = (k <= 3);
    end
    pix_vld = 1'b0;
    check("timeout_latency", k, TO);
    check("err_leds", {led_busy, led_pass, done}, 3'b000);
    check("no_proto_on_timeout", err_proto, 1'b0);

    // Restart from ERR, then an extra pixel in WAIT_RES and a reset mid-HOLD.
    fork
      press_key();
    join_none
    wait_start(lat);
    check("restart_idx", img_idx, 1'b0);
    check("restart_clears_timeout", err_timeout, 1'b0);
    @(negedge clk);
    pix_vld = 1'b1;
    repeat (4) @(negedge clk);
    @(negedge clk);
    pix_vld = 1'b0;
    res_vld = 1'b1;
    res_end = 1'b1;
    res_din = vecs[0].scores;
    @(negedge clk);
    res_vld = 1'b0;
    res_end = 1'b0;
    check("err_proto_extra_pix", err_proto, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check("in_hold_before_reset", {led_busy, pred_label}, {1'b1, 4'd3});
    rst = 1'b1;
    @(negedge clk);
    check("reset_mid_hold", all_outs(), '0);
    rst = 1'b0;
    snap = start_cnt;
    repeat (15) @(negedge clk);
    check("no_start_after_reset", start_cnt - snap, 0);
    check("quiet_after_reset", all_outs(), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mnist_verify_ctrl.md
Name: mnist_verify_ctrl

Overview:
- Parametrised successor to the single-shot on-board MNIST verification harness.
- On one debounced key press, it runs a batch of NUM_IMG test images through the image source and the mnist core.
- For each image it captures the per-class score vector, computes the argmax and compares it against an expected label.
- It reports per-image and batch pass/fail on LEDs with a hold timer, and adds timeout and protocol-error detection.

Parameters:
NUM_CLASS, 10, number of class scores in the result vector
SCORE_W, 8, width of each score (signed two's complement)
PIX_PER_IMG, 784, pixels streamed per image
NUM_IMG, 4, images per batch (>=1)
DEBOUNCE_CYCLES, 1000000, cycles the key must be stable before it is accepted
HOLD_CYCLES, 50000000, per-image LED display time
TIMEOUT_CYCLES, 2000000, maximum cycles from img_start to the captured result

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
key_in  in  1  raw push-button, asynchronous, active-high
img_start  out  1  one-cycle pulse that starts streaming image img_idx
img_idx  out  $clog2(NUM_IMG) (min 1)  current image index, also addresses the expected-label ROM
pix_vld  in  1  image-source pixel valid (counted only, data not used)
exp_label  in  $clog2(NUM_CLASS)  expected class for img_idx, valid whenever img_idx is stable
res_din  in  NUM_CLASS*SCORE_W  score vector; class k occupies bits [k*SCORE_W +: SCORE_W]
res_vld  in  1  result valid
res_end  in  1  final result of the image
pred_label  out  $clog2(NUM_CLASS)  registered argmax of the last image
led_pass  out  1  pass indicator
led_busy  out  1  high while a batch is running
pass_cnt  out  $clog2(NUM_IMG+1)  images passed in the current batch
fail_cnt  out  $clog2(NUM_IMG+1)  images failed in the current batch
done  out  1  batch complete
err_timeout  out  1  sticky timeout flag
err_proto  out  1  sticky protocol-error flag

Behaviour:
- Reset: every output is 0 and the FSM is in IDLE. Reset mid-run aborts immediately; no further img_start is issued.
- Key path:
  - 2-FF synchroniser, then the debouncer.
  - The debounced level changes only after the synchronised input has been stable for DEBOUNCE_CYCLES consecutive cycles.
  - The rising edge of the debounced level produces a one-cycle key_go.
  - key_go is honoured only in IDLE, DONE and ERR; it is ignored otherwise.
- FSM states: IDLE, START, STREAM, WAIT_RES, COMPARE, HOLD, NEXT, DONE, ERR.
- IDLE --key_go--> START:
  - clears img_idx, pass_cnt, fail_cnt, done, err_timeout and err_proto;
  - sets led_busy to 1.
- START: img_start=1 for exactly one cycle; clears the pixel counter and the timeout counter; next state STREAM.
- STREAM:
  - counts pix_vld;
  - on the pix_vld that reaches PIX_PER_IMG, goes to WAIT_RES in the following cycle.
- WAIT_RES: on a cycle with res_vld & res_end, registers res_din and goes to COMPARE. res_vld without res_end is ignored.
- COMPARE (1 cycle):
  - signed argmax over the captured vector; ties resolve to the lowest index;
  - pred_label is registered;
  - if pred==exp_label, pass_cnt++ and led_pass=1; otherwise fail_cnt++ and led_pass=0.
- HOLD:
  - led_pass is held for HOLD_CYCLES, counted from entry;
  - led_pass is cleared on exit;
  - next state NEXT.
- NEXT:
  - if img_idx==NUM_IMG-1, go to DONE;
  - otherwise img_idx++ and go to START.
- DONE:
  - done=1, led_busy=0, led_pass=(fail_cnt==0), held steadily;
  - key_go starts a new batch: counters cleared, behaviour as in IDLE.
- Timeout:
  - the timeout counter runs in STREAM and WAIT_RES;
  - reaching TIMEOUT_CYCLES sets err_timeout and goes to ERR.
- Protocol errors: err_proto is set sticky, and the FSM keeps running, on any of:
  - pix_vld outside STREAM;
  - res_vld & res_end outside WAIT_RES.
- ERR: led_busy=0, led_pass=0; key_go restarts a batch (same as IDLE).
- Simultaneous last pix_vld and res_end in STREAM: this is a protocol error. The FSM still enters WAIT_RES and waits for the next result.
- Counters saturate and never wrap. Sizing rules:
  - pixel counter: $clog2(PIX_PER_IMG+1) bits;
  - hold counter: $clog2(HOLD_CYCLES+1) bits;
  - timeout counter: $clog2(TIMEOUT_CYCLES+1) bits.

Decomposition:
- Package mnist_verify_pkg: FSM state enum; localparams CLS_W=$clog2(NUM_CLASS) and IDX_W; a signed-argmax function parametrised by NUM_CLASS and SCORE_W.
- Sub-module key_debounce (parameter DEBOUNCE_CYCLES): ports clk, rst, din, level, rise_pulse.

Test Plan:
All scenarios use small parameters: PIX_PER_IMG=4, NUM_IMG=2, DEBOUNCE_CYCLES=3, HOLD_CYCLES=5, TIMEOUT_CYCLES=20.
1. Key bounce 1-0-1 shorter than 3 cycles, then held high for 10 cycles -> exactly one img_start, issued within 6 cycles of the stable edge; a second press mid-run produces no extra img_start.
2. Image 0: scores {k=3:+100, others:-5}, exp=3. Image 1: scores {k=7:+50}, exp=2 -> pred_label 3 then 7; led_pass high for 5 cycles, then low for 5; pass_cnt=1, fail_cnt=1, done=1, led_pass=0 in DONE.
3. Tie: scores with k=2 and k=5 both +20, exp=2 -> pred_label=2, pass.
4. Signed check: all scores negative except k=9 = 8'h00, which must beat k=0 = 8'h80 (-128) -> pred_label=9.
5. Only 3 pixels sent -> err_timeout=1 exactly 20 cycles after img_start, FSM in ERR; next key_go clears err_timeout and restarts from img_idx=0.
6. Extra pix_vld in WAIT_RES, then reset asserted mid-HOLD -> err_proto=1 before reset; all outputs 0 the cycle after reset.
